// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and types for the sorter output collector
package sort_pkg;

    localparam int N_ENTRY = 32;
    localparam int IDX_W   = 5;
    localparam int COLOR_W = 2;
    localparam int CNT_W   = IDX_W + 1;
    localparam int N_COLOR = 1 << COLOR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [IDX_W-1:0]   index;
    } entry_t;

endpackage

// File: rtl/sort_rank_ram.sv
// rtl/sort_rank_ram.sv - rank-addressed entry buffer with registered read
module sort_rank_ram
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  entry_t           wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output entry_t           rd_data
);

    entry_t mem [N_ENTRY];

    // Contents are not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sort_collector.sv
// rtl/sort_collector.sv - captures one ranked sorter frame, tallies colors, checks indices
module sort_collector
    import sort_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic [COLOR_W-1:0]     s_color,
    input  logic [IDX_W-1:0]       s_index,
    input  logic                   clear,
    input  logic                   rd_en,
    input  logic [IDX_W-1:0]       rd_rank,
    output logic                   rd_valid,
    output logic [COLOR_W-1:0]     rd_color,
    output logic [IDX_W-1:0]       rd_index,
    output logic                   frame_done,
    output logic [4*CNT_W-1:0]     color_hist,
    output logic                   dup_err,
    output logic                   overrun_err
);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rank;
    logic [N_ENTRY-1:0] seen;
    logic [CNT_W-1:0]   hist [N_COLOR];
    logic               accept;
    logic               rd_accept;
    entry_t             wr_entry;
    entry_t             rd_entry;

    // clear drops any coincident beat; DONE ignores beats entirely.
    assign accept    = s_valid && !clear && (state != DONE);
    assign rd_accept = rd_en && (state == DONE);
    assign wr_entry  = '{color: s_color, index: s_index};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = COLLECT;
            COLLECT: if (accept && rank == IDX_W'(N_ENTRY - 1)) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rank        <= '0;
            seen        <= '0;
            dup_err     <= 1'b0;
            overrun_err <= 1'b0;
            frame_done  <= 1'b0;
            for (int c = 0; c < N_COLOR; c++) begin
                hist[c] <= '0;
            end
        end else begin
            frame_done <= (state_nx == DONE);
            if (accept) begin
                rank            <= rank + IDX_W'(1);
                seen[s_index]   <= 1'b1;
                hist[s_color]   <= hist[s_color] + CNT_W'(1);
                if (seen[s_index]) begin
                    dup_err <= 1'b1;
                end
            end
            if (s_valid && state == DONE) begin
                overrun_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
        end
    end

    sort_rank_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (rank),
        .wr_data (wr_entry),
        .rd_en   (rd_accept),
        .rd_addr (rd_rank),
        .rd_data (rd_entry)
    );

    assign rd_color = rd_entry.color;
    assign rd_index = rd_entry.index;

    for (genvar g = 0; g < N_COLOR; g++) begin : g_hist
        assign color_hist[g*CNT_W +: CNT_W] = hist[g];
    end

endmodule

// File: tb/tb_sort_collector.sv
// tb/tb_sort_collector.sv - randomized self-checking bench for sort_collector
module tb_sort_collector;
    import sort_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic [COLOR_W-1:0] s_color = '0;
    logic [IDX_W-1:0]   s_index = '0;
    logic               clear = 1'b0;
    logic               rd_en = 1'b0;
    logic [IDX_W-1:0]   rd_rank = '0;
    logic               rd_valid;
    logic [COLOR_W-1:0] rd_color;
    logic [IDX_W-1:0]   rd_index;
    logic               frame_done;
    logic [4*CNT_W-1:0] color_hist;
    logic               dup_err;
    logic               overrun_err;

    always #5 clk = ~clk;

    sort_collector dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_color     (s_color),
        .s_index     (s_index),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_rank     (rd_rank),
        .rd_valid    (rd_valid),
        .rd_color    (rd_color),
        .rd_index    (rd_index),
        .frame_done  (frame_done),
        .color_hist  (color_hist),
        .dup_err     (dup_err),
        .overrun_err (overrun_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the frame as a list of beats in arrival order.
    int   m_cnt;
    int   m_col [32];
    int   m_idx [32];
    int   m_hist [4];
    bit   m_seen [32];
    bit   m_dup, m_over;
    bit   m_rv;
    int   m_rc, m_ri;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_frame();
        m_cnt = 0;
        m_dup = 0;
        m_over = 0;
        for (int c = 0; c < 4; c++) m_hist[c] = 0;
        for (int i = 0; i < 32; i++) m_seen[i] = 0;
    endtask

    task automatic check_all(input string where);
        logic [23:0] h;
        h = {m_hist[3][5:0], m_hist[2][5:0], m_hist[1][5:0], m_hist[0][5:0]};
        check({where, ":frame_done"}, 32'(frame_done), 32'(m_cnt == 32));
        check({where, ":color_hist"}, 32'(color_hist), 32'(h));
        check({where, ":dup_err"}, 32'(dup_err), 32'(m_dup));
        check({where, ":overrun_err"}, 32'(overrun_err), 32'(m_over));
        check({where, ":rd_valid"}, 32'(rd_valid), 32'(m_rv));
        check({where, ":rd_color"}, 32'(rd_color), 32'(m_rc));
        check({where, ":rd_index"}, 32'(rd_index), 32'(m_ri));
    endtask

    task automatic step(input bit v, input int c, input int i, input bit clr,
                        input bit re, input int rr, input string where);
        bit done;
        s_valid = v; s_color = c[1:0]; s_index = i[4:0];
        clear = clr; rd_en = re; rd_rank = rr[4:0];
        @(posedge clk);
        done = (m_cnt == 32);
        m_rv = re && done;
        if (re && done) begin
            m_rc = m_col[rr];
            m_ri = m_idx[rr];
        end
        if (clr) begin
            model_clear_frame();
        end else if (v) begin
            if (done) begin
                m_over = 1;
            end else begin
                if (m_seen[i]) m_dup = 1;
                m_seen[i] = 1;
                m_col[m_cnt] = c;
                m_idx[m_cnt] = i;
                m_hist[c]++;
                m_cnt++;
            end
        end
        @(negedge clk);
        s_valid = 0; clear = 0; rd_en = 0;
        check_all(where);
    endtask

    task automatic beat(input int c, input int i);
        step(1, c, i, 0, 0, 0, "beat");
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic rd(input int r);
        step(0, 0, 0, 0, 1, r, "read");
    endtask

    task automatic clr();
        step(0, 0, 0, 1, 0, 0, "clear");
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        model_clear_frame();
        m_rv = 0; m_rc = 0; m_ri = 0;
        @(negedge clk);
        rst = 0;
        check_all("reset");
    endtask

    task automatic read_all();
        for (int r = 0; r < 32; r++) step(0, 0, 0, 0, 1, r, "burst");
    endtask

    task automatic directed_frame(input bit gaps, input int dup_k);
        for (int k = 0; k < 32; k++) begin
            beat(k % 4, (k == dup_k) ? 7 : 31 - k);
            if (k < 31) check("early_done", 32'(frame_done), 32'd0);
            if (gaps && (k == 5 || k == 20)) repeat (3) idle();
        end
        check("done_after_last", 32'(frame_done), 32'd1);
    endtask

    task automatic rand_frame(input int n, input bit allow_dup);
        int perm [32];
        int j, t;
        for (int i = 0; i < 32; i++) perm[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(7, 0))
                0: idle();
                1: rd($urandom_range(31, 0));
                default: ;
            endcase
            if (allow_dup && $urandom_range(15, 0) == 0) beat($urandom_range(3, 0), $urandom_range(31, 0));
            else beat($urandom_range(3, 0), perm[k]);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        directed_frame(0, -1);
        check("hist_c0", 32'(color_hist[5:0]), 32'd8);
        check("hist_c3", 32'(color_hist[23:18]), 32'd8);
        rd(0);
        check("rank0_index", 32'(rd_index), 32'd31);
        check("rank0_color", 32'(rd_color), 32'd0);
        rd(31);
        check("rank31_index", 32'(rd_index), 32'd0);
        check("rank31_color", 32'(rd_color), 32'd3);
        read_all();

        clr();
        directed_frame(1, -1);
        read_all();

        clr();
        directed_frame(0, 10);
        check("dup_sticky", 32'(dup_err), 32'd1);
        beat(2, 4);
        check("overrun", 32'(overrun_err), 32'd1);
        read_all();

        clr();
        rand_frame(12, 0);
        rd(3);
        check("rd_in_collect", 32'(rd_valid), 32'd0);
        clr();
        rand_frame(32, 0);
        read_all();
        rd(5);
        check("rd5_valid", 32'(rd_valid), 32'd1);

        step(1, 1, 3, 1, 1, 9, "clear_with_read");
        rand_frame(32, 1);
        beat(0, 0);
        do_reset();
        check("reset_done", 32'(frame_done), 32'd0);

        for (int f = 0; f < 6; f++) begin
            rand_frame($urandom_range(32, 20), 1);
            repeat (4) begin
                if ($urandom_range(3, 0) == 0) beat($urandom_range(3, 0), $urandom_range(31, 0));
                rd($urandom_range(31, 0));
            end
            if (f == 3) do_reset();
            else clr();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
